dl_router: RTL

//  Parametrised ROM-download router between the HPS ioctl stream and the game core.

---
 rtl/dl_router.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dl_router.sv
// ROM-download router: decodes the ioctl stream into per-channel word writes and holds the core in reset.
// Optional DL_CHECKSUM_EN adds a running 8-bit sum of the accepted bytes on dl_sum.
`timescale 1ns/1ps
module dl_router #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned INDEX_BASE  = 0,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                clk_4m,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic [7:0]          ioctl_index,
  output logic                ioctl_wait,
  output logic [ADDR_W-1:0]   dn_addr,
  output logic [DATA_W-1:0]   dn_data,
  output logic [CHANNELS-1:0] dn_wr,
  input  logic [CHANNELS-1:0] dn_ready,
  output logic                core_reset,
  output logic                dl_overflow,
  output logic [7:0]          dl_sum
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LB    = $clog2(BYTES);
  localparam int unsigned LW    = (LB == 0) ? 1 : LB;
  localparam int unsigned HW    = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD} state_t;

  state_t              state;
  logic [HW-1:0]       hold_cnt;
  logic [DATA_W-1:0]   word_buf;
  logic                pend;
  logic [CHANNELS-1:0] ch_q;
  logic [ADDR_W-1:0]   addr_q;

  // Byte decode: target channel, lane within the word, word address and range checks
  logic [7:0]          ch_raw;
  logic                ch_ok;
  logic [CHANNELS-1:0] ch_onehot;
  logic [LW-1:0]       lane;
  logic [ADDR_W-1:0]   waddr;
  logic                addr_ok;
  logic                take;
  logic                drop;
  logic                last;
  logic                ack;
  logic [DATA_W-1:0]   merged;

  assign ch_raw    = ioctl_index - 8'(INDEX_BASE);
  assign ch_ok     = 32'(ch_raw) < CHANNELS;
  assign ch_onehot = CHANNELS'(1) << ch_raw;
  assign lane      = LW'(ioctl_addr & 25'(BYTES - 1));
  assign waddr     = ADDR_W'(ioctl_addr >> LB);
  assign addr_ok   = (ioctl_addr >> (ADDR_W + LB)) == 25'd0;
  assign take      = (state == S_LOAD) && ioctl_wr && !ioctl_wait && ch_ok && addr_ok;
  assign drop      = (state == S_LOAD) && ioctl_wr && !take;
  assign last      = lane == LW'(BYTES - 1);
  assign ack       = |(dn_wr & dn_ready);

  // Current word buffer with the incoming byte merged into its lane
  always_comb begin
    merged = word_buf;
    for (int i = 0; i < BYTES; i++) begin
      if (lane == LW'(i)) merged[8*i +: 8] = ioctl_dout;
    end
  end

  always_ff @(posedge clk_4m or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_HOLD;
      hold_cnt    <= HW'(HOLD_CYCLES);
      word_buf    <= '0;
      pend        <= 1'b0;
      ch_q        <= '0;
      addr_q      <= '0;
      ioctl_wait  <= 1'b0;
      dn_addr     <= '0;
      dn_data     <= '0;
      dn_wr       <= '0;
      core_reset  <= 1'b1;
      dl_overflow <= 1'b0;
    end else begin
      if (ack) begin
        dn_wr      <= '0;
        ioctl_wait <= 1'b0;
      end
      if (drop) dl_overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          core_reset <= 1'b0;
          if (ioctl_download) begin
            state       <= S_LOAD;
            core_reset  <= 1'b1;
            dl_overflow <= 1'b0;
            word_buf    <= '0;
            pend        <= 1'b0;
          end
        end
        S_LOAD: begin
          if (take) begin
            ch_q   <= ch_onehot;
            addr_q <= waddr;
            if (last) begin
              dn_wr      <= ch_onehot;
              ioctl_wait <= 1'b1;
              dn_addr    <= waddr;
              dn_data    <= merged;
              word_buf   <= '0;
              pend       <= 1'b0;
            end else begin
              word_buf <= merged;
              pend     <= 1'b1;
            end
          end
          // A byte completing its word in the same cycle as the fall leaves nothing to drain
          if (!ioctl_download) begin
            if (take ? !last : pend) begin
              state <= S_DRAIN;
            end else begin
              state    <= S_HOLD;
              hold_cnt <= HW'(HOLD_CYCLES);
            end
          end
        end
        S_DRAIN: begin
          if (pend) begin
            if (dn_wr == '0) begin
              dn_wr      <= ch_q;
              ioctl_wait <= 1'b1;
              dn_addr    <= addr_q;
              dn_data    <= word_buf;
              word_buf   <= '0;
              pend       <= 1'b0;
            end
          end else if (dn_wr == '0 || ack) begin
            state    <= S_HOLD;
            hold_cnt <= HW'(HOLD_CYCLES);
          end
        end
        S_HOLD: begin
          if (ioctl_download) begin
            state    <= S_LOAD;
            hold_cnt <= HW'(HOLD_CYCLES);
          end else if (hold_cnt <= HW'(1)) begin
            state      <= S_IDLE;
            core_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

`ifdef DL_CHECKSUM_EN
  // Running sum of accepted bytes, restarted when a new download begins
  always_ff @(posedge clk_4m or negedge reset_n) begin
    if (!reset_n) begin
      dl_sum <= 8'h00;
    end else if (state == S_IDLE && ioctl_download) begin
      dl_sum <= 8'h00;
    end else if (take) begin
      dl_sum <= dl_sum + ioctl_dout;
    end
  end
`else
  assign dl_sum = 8'h00;
`endif

endmodule
